// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register
// and saturating stall/flush event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_IF_ID,
    input  logic             flush_IF,
    input  logic [1:0]       ID_PCSrc,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      jr_target,
    input  logic             exc_req,
    input  logic [31:0]      IF_Instruction,
    output logic [31:0]      IF_PC,
    output logic [31:0]      ID_Instruction,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_PC_plus4,
    output logic             ID_Valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '0;

    logic [31:0]      pc_q, pc_d;
    if_id_t           if_id_q, if_id_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] target_raw;
    logic [31:0] next_pc;

    // Next-PC target selection; low two bits always cleared to keep word alignment.
    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        target_raw = pc_plus4;
        unique case (ID_PCSrc)
            2'b01:   target_raw = branch_taken ? branch_target : pc_plus4;
            2'b10:   target_raw = jump_target;
            2'b11:   target_raw = jr_target;
            default: target_raw = pc_plus4;
        endcase
        next_pc = target_raw & ~32'h0000_0003;
    end

    // Per-edge update: exception beats stall, stall beats flush.
    always_comb begin
        pc_d        = pc_q;
        if_id_d     = if_id_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (exc_req) begin
            pc_d    = EXC_VECTOR;
            if_id_d = BUBBLE;
        end else if (stall_IF_ID) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (flush_IF) begin
            pc_d    = next_pc;
            if_id_d = BUBBLE;
            if (flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else begin
            pc_d             = next_pc;
            if_id_d.instr    = IF_Instruction;
            if_id_d.pc       = pc_q;
            if_id_d.pc_plus4 = pc_plus4;
            if_id_d.valid    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            if_id_q     <= BUBBLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            if_id_q     <= if_id_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign IF_PC          = pc_q;
    assign ID_Instruction = if_id_q.instr;
    assign ID_PC          = if_id_q.pc;
    assign ID_PC_plus4    = if_id_q.pc_plus4;
    assign ID_Valid       = if_id_q.valid;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule
